// File: rtl/mure_block_packer.sv
// Multi-retire instruction block packer: folds up to NRET retired uops per cycle into
// blocks and queues them in a multi-push FIFO. Optional feature macro: MURE_PRIV_SPLIT_EN.
module mure_block_packer #(
    parameter int NRET        = 2,
    parameter int DEPTH       = 8,
    parameter int XLEN        = 32,
    parameter int ITYPE_LEN   = 3,
    parameter int IRETIRE_LEN = 32,
    parameter int PRIV_LEN    = 2
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic [NRET-1:0]             in_valid_i,
    input  logic [NRET*XLEN-1:0]        in_pc_i,
    input  logic [NRET*ITYPE_LEN-1:0]   in_itype_i,
    input  logic [NRET-1:0]             in_compressed_i,
    input  logic [NRET*PRIV_LEN-1:0]    in_priv_i,
    output logic                        in_ready_o,
    input  logic                        flush_i,
    output logic                        out_valid_o,
    input  logic                        out_ready_i,
    output logic [XLEN-1:0]             out_iaddr_o,
    output logic [IRETIRE_LEN-1:0]      out_iretire_o,
    output logic                        out_ilastsize_o,
    output logic [ITYPE_LEN-1:0]        out_itype_o,
    output logic [PRIV_LEN-1:0]         out_priv_o
);

`ifdef MURE_PRIV_SPLIT_EN
    // A privilege change can close a block before the lane's own close: two pushes per lane.
    localparam int MAXP = 2*NRET + 1;
`else
    localparam int MAXP = NRET + 1;
`endif
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [IRETIRE_LEN-1:0] SAT_LIM = {IRETIRE_LEN{1'b1}} - IRETIRE_LEN'(2);

    typedef struct packed {
        logic [XLEN-1:0]        iaddr;
        logic [IRETIRE_LEN-1:0] iretire;
        logic                   ilastsize;
        logic [ITYPE_LEN-1:0]   itype;
        logic [PRIV_LEN-1:0]    priv;
    } blk_t;

    typedef blk_t [MAXP-1:0] blk_vec_t;

    typedef enum logic {S_IDLE, S_COUNT} state_t;

    function automatic logic [IRETIRE_LEN-1:0] hw_add(input logic [IRETIRE_LEN-1:0] c,
                                                      input logic comp);
        return c + (comp ? IRETIRE_LEN'(1) : IRETIRE_LEN'(2));
    endfunction

    // Close early while one more 4-byte add still fits in the counter.
    function automatic logic sat_hit(input logic [IRETIRE_LEN-1:0] c);
        return c > SAT_LIM;
    endfunction

    function automatic logic itype_closes(input logic [ITYPE_LEN-1:0] t);
        return (t != '0) && (t != ITYPE_LEN'(7));
    endfunction

    function automatic blk_t mk_blk(input logic [XLEN-1:0] a, input logic [IRETIRE_LEN-1:0] c,
                                    input logic l, input logic [ITYPE_LEN-1:0] t,
                                    input logic [PRIV_LEN-1:0] p);
        blk_t b;
        b.iaddr     = a;
        b.iretire   = c;
        b.ilastsize = l;
        b.itype     = t;
        b.priv      = p;
        return b;
    endfunction

    function automatic blk_vec_t put(input blk_vec_t v, input int n, input blk_t e);
        blk_vec_t r;
        r = v;
        for (int k = 0; k < MAXP; k++) begin
            if (k == n) r[k] = e;
        end
        return r;
    endfunction

    state_t                 state_q, state_n;
    logic [IRETIRE_LEN-1:0] cnt_q, cnt_n;
    logic [XLEN-1:0]        start_q, start_n;
    logic [PRIV_LEN-1:0]    priv_q, priv_n;
    logic                   last_q, last_n;

    blk_t                   mem [DEPTH];
    logic [AW-1:0]          wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]          fill_q, fill_n;
    logic                   rdy_q;

    blk_vec_t               push_v;
    int                     npush;
    logic                   accept;
    logic                   pop;
    blk_t                   head;

    assign accept = rdy_q;
    assign pop    = out_valid_o && out_ready_i;

    always_comb begin
        state_n = state_q;
        cnt_n   = cnt_q;
        start_n = start_q;
        priv_n  = priv_q;
        last_n  = last_q;
        push_v  = '0;
        npush   = 0;
        for (int i = 0; i < NRET; i++) begin
            if (accept && in_valid_i[i]) begin
`ifdef MURE_PRIV_SPLIT_EN
                if (state_n == S_COUNT && in_priv_i[i*PRIV_LEN +: PRIV_LEN] != priv_n) begin
                    push_v  = put(push_v, npush, mk_blk(start_n, cnt_n, last_n, '0, priv_n));
                    npush   = npush + 1;
                    state_n = S_IDLE;
                end
`endif
                if (state_n == S_IDLE) begin
                    start_n = in_pc_i[i*XLEN +: XLEN];
                    priv_n  = in_priv_i[i*PRIV_LEN +: PRIV_LEN];
                    cnt_n   = '0;
                    state_n = S_COUNT;
                end
                cnt_n  = hw_add(cnt_n, in_compressed_i[i]);
                last_n = ~in_compressed_i[i];
                if (itype_closes(in_itype_i[i*ITYPE_LEN +: ITYPE_LEN])) begin
                    push_v  = put(push_v, npush, mk_blk(start_n, cnt_n, last_n,
                                  in_itype_i[i*ITYPE_LEN +: ITYPE_LEN], priv_n));
                    npush   = npush + 1;
                    state_n = S_IDLE;
                end else if (sat_hit(cnt_n)) begin
                    push_v  = put(push_v, npush, mk_blk(start_n, cnt_n, last_n, '0, priv_n));
                    npush   = npush + 1;
                    state_n = S_IDLE;
                end
            end
        end
        if (accept && flush_i && state_n == S_COUNT) begin
            push_v  = put(push_v, npush, mk_blk(start_n, cnt_n, last_n, '0, priv_n));
            npush   = npush + 1;
            state_n = S_IDLE;
        end
        fill_n = fill_q + CW'(npush) - CW'(pop);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            fill_q   <= '0;
            rdy_q    <= 1'b1;
        end else begin
            state_q  <= state_n;
            cnt_q    <= cnt_n;
            wr_ptr_q <= wr_ptr_q + AW'(npush);
            rd_ptr_q <= rd_ptr_q + AW'(pop);
            fill_q   <= fill_n;
            rdy_q    <= (DEPTH - int'(fill_n)) >= MAXP;
        end
    end

    // Block payload and FIFO storage carry no reset; validity comes from state/fill.
    always_ff @(posedge clk_i) begin
        start_q <= start_n;
        priv_q  <= priv_n;
        last_q  <= last_n;
        for (int k = 0; k < MAXP; k++) begin
            if (k < npush) mem[wr_ptr_q + AW'(k)] <= push_v[k];
        end
    end

    assign head            = mem[rd_ptr_q];
    assign in_ready_o      = rdy_q;
    assign out_valid_o     = (fill_q != '0);
    assign out_iaddr_o     = out_valid_o ? head.iaddr     : '0;
    assign out_iretire_o   = out_valid_o ? head.iretire   : '0;
    assign out_ilastsize_o = out_valid_o ? head.ilastsize : 1'b0;
    assign out_itype_o     = out_valid_o ? head.itype     : '0;
    assign out_priv_o      = out_valid_o ? head.priv      : '0;

endmodule

// File: tb/tb_mure_block_packer.sv
// Directed bench for mure_block_packer: vector table plus hand sequences for
// backpressure, counter saturation (IRETIRE_LEN=4 instance) and mid-stream reset.
module tb_mure_block_packer;

`ifdef MURE_PRIV_SPLIT_EN
    localparam int NEED = 5;
`else
    localparam int NEED = 3;
`endif
    localparam int DEPTH = 8;
    localparam int NFILL = DEPTH - NEED + 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic [1:0]  a_valid, a_comp;
    logic [63:0] a_pc;
    logic [5:0]  a_itype;
    logic [3:0]  a_priv;
    logic        a_flush, a_ordy, a_ird, a_ov, a_last;
    logic [31:0] a_iaddr, a_iret;
    logic [2:0]  a_it;
    logic [1:0]  a_prv;

    logic [1:0]  b_valid, b_comp;
    logic [63:0] b_pc;
    logic [5:0]  b_itype;
    logic [3:0]  b_priv;
    logic        b_flush, b_ordy, b_ird, b_ov, b_last;
    logic [31:0] b_iaddr;
    logic [3:0]  b_iret;
    logic [2:0]  b_it;
    logic [1:0]  b_prv;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mure_block_packer #(.NRET(2), .DEPTH(DEPTH), .XLEN(32), .ITYPE_LEN(3),
                        .IRETIRE_LEN(32), .PRIV_LEN(2)) dut_a (
        .clk_i(clk), .rst_i(rst), .in_valid_i(a_valid), .in_pc_i(a_pc),
        .in_itype_i(a_itype), .in_compressed_i(a_comp), .in_priv_i(a_priv),
        .in_ready_o(a_ird), .flush_i(a_flush), .out_valid_o(a_ov), .out_ready_i(a_ordy),
        .out_iaddr_o(a_iaddr), .out_iretire_o(a_iret), .out_ilastsize_o(a_last),
        .out_itype_o(a_it), .out_priv_o(a_prv)
    );

    mure_block_packer #(.NRET(2), .DEPTH(DEPTH), .XLEN(32), .ITYPE_LEN(3),
                        .IRETIRE_LEN(4), .PRIV_LEN(2)) dut_b (
        .clk_i(clk), .rst_i(rst), .in_valid_i(b_valid), .in_pc_i(b_pc),
        .in_itype_i(b_itype), .in_compressed_i(b_comp), .in_priv_i(b_priv),
        .in_ready_o(b_ird), .flush_i(b_flush), .out_valid_o(b_ov), .out_ready_i(b_ordy),
        .out_iaddr_o(b_iaddr), .out_iretire_o(b_iret), .out_ilastsize_o(b_last),
        .out_itype_o(b_it), .out_priv_o(b_prv)
    );

    typedef struct {
        logic [1:0]  vld;
        logic [31:0] pc0, pc1;
        logic [2:0]  it0, it1;
        logic [1:0]  cmp, prv;
        logic        fl, pp;
        logic        ev;
        logic [31:0] ea, er;
        logic        el;
        logic [2:0]  eit;
        logic [1:0]  ep;
    } vec_t;

    vec_t vt [12];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_a(input logic [1:0] vld, input logic [31:0] pc0, input logic [31:0] pc1,
                         input logic [2:0] it0, input logic [2:0] it1, input logic [1:0] cmp,
                         input logic [1:0] prv, input logic fl, input logic pp);
        a_valid = vld;
        a_pc    = {pc1, pc0};
        a_itype = {it1, it0};
        a_comp  = cmp;
        a_priv  = {prv, prv};
        a_flush = fl;
        a_ordy  = pp;
    endtask

    task automatic chk_a(input string tag, input logic ev, input logic [31:0] ea,
                         input logic [31:0] er, input logic el, input logic [2:0] eit,
                         input logic [1:0] ep);
        chk({tag, ".valid"}, 64'(a_ov), 64'(ev));
        chk({tag, ".iaddr"}, 64'(a_iaddr), 64'(ea));
        chk({tag, ".iretire"}, 64'(a_iret), 64'(er));
        chk({tag, ".lastsize"}, 64'(a_last), 64'(el));
        chk({tag, ".itype"}, 64'(a_it), 64'(eit));
        chk({tag, ".priv"}, 64'(a_prv), 64'(ep));
    endtask

    initial begin
        set_a(2'b00, 32'h0, 32'h0, 3'd0, 3'd0, 2'b00, 2'd0, 1'b0, 1'b0);
        b_valid = 2'b00; b_pc = 64'h0; b_itype = 6'h0; b_comp = 2'b00;
        b_priv = 4'h0; b_flush = 1'b0; b_ordy = 1'b0;

        // rows: vld pc0 pc1 it0 it1 cmp prv flush pop | valid iaddr iretire last itype priv
        vt[0]  = '{2'b11, 32'h100, 32'h104, 3'd0, 3'd5, 2'b10, 2'd3, 1'b0, 1'b0,
                   1'b1, 32'h100, 32'd3, 1'b0, 3'd5, 2'd3};
        vt[1]  = '{2'b11, 32'h200, 32'h300, 3'd1, 3'd3, 2'b00, 2'd3, 1'b0, 1'b1,
                   1'b1, 32'h200, 32'd2, 1'b1, 3'd1, 2'd3};
        vt[2]  = '{2'b00, 32'h0, 32'h0, 3'd0, 3'd0, 2'b00, 2'd3, 1'b0, 1'b1,
                   1'b1, 32'h300, 32'd2, 1'b1, 3'd3, 2'd3};
        vt[3]  = '{2'b00, 32'h0, 32'h0, 3'd0, 3'd0, 2'b00, 2'd3, 1'b0, 1'b1,
                   1'b0, 32'h0, 32'd0, 1'b0, 3'd0, 2'd0};
        vt[4]  = '{2'b11, 32'h500, 32'h504, 3'd0, 3'd0, 2'b00, 2'd3, 1'b0, 1'b0,
                   1'b0, 32'h0, 32'd0, 1'b0, 3'd0, 2'd0};
        vt[5]  = '{2'b00, 32'h0, 32'h0, 3'd0, 3'd0, 2'b00, 2'd3, 1'b0, 1'b0,
                   1'b0, 32'h0, 32'd0, 1'b0, 3'd0, 2'd0};
        vt[6]  = '{2'b00, 32'h0, 32'h0, 3'd0, 3'd0, 2'b00, 2'd3, 1'b1, 1'b0,
                   1'b1, 32'h500, 32'd4, 1'b1, 3'd0, 2'd3};
        vt[7]  = '{2'b00, 32'h0, 32'h0, 3'd0, 3'd0, 2'b00, 2'd3, 1'b1, 1'b1,
                   1'b0, 32'h0, 32'd0, 1'b0, 3'd0, 2'd0};
        vt[8]  = '{2'b10, 32'hDEAD, 32'h600, 3'd4, 3'd2, 2'b10, 2'd1, 1'b0, 1'b0,
                   1'b1, 32'h600, 32'd1, 1'b0, 3'd2, 2'd1};
        vt[9]  = '{2'b01, 32'h700, 32'h0, 3'd7, 3'd0, 2'b01, 2'd2, 1'b0, 1'b1,
                   1'b0, 32'h0, 32'd0, 1'b0, 3'd0, 2'd0};
        vt[10] = '{2'b01, 32'h702, 32'h0, 3'd0, 3'd0, 2'b01, 2'd2, 1'b1, 1'b0,
                   1'b1, 32'h700, 32'd2, 1'b0, 3'd0, 2'd2};
        vt[11] = '{2'b00, 32'h0, 32'h0, 3'd0, 3'd0, 2'b00, 2'd2, 1'b0, 1'b1,
                   1'b0, 32'h0, 32'd0, 1'b0, 3'd0, 2'd0};

        // reset state
        tick();
        tick();
        chk_a("reset", 1'b0, 32'h0, 32'd0, 1'b0, 3'd0, 2'd0);
        chk("reset.in_ready", 64'(a_ird), 64'(1'b1));
        @(negedge clk);
        rst = 1'b0;

        // table vectors
        for (int i = 0; i < 12; i++) begin
            set_a(vt[i].vld, vt[i].pc0, vt[i].pc1, vt[i].it0, vt[i].it1, vt[i].cmp,
                  vt[i].prv, vt[i].fl, vt[i].pp);
            tick();
            chk_a($sformatf("vec%0d", i), vt[i].ev, vt[i].ea, vt[i].er, vt[i].el,
                  vt[i].eit, vt[i].ep);
            chk($sformatf("vec%0d.in_ready", i), 64'(a_ird), 64'(1'b1));
        end

        // privilege change inside an open block
        set_a(2'b01, 32'hA00, 32'h0, 3'd0, 3'd0, 2'b00, 2'd3, 1'b0, 1'b0);
        tick();
        set_a(2'b01, 32'hA04, 32'h0, 3'd0, 3'd0, 2'b00, 2'd0, 1'b1, 1'b0);
        tick();
        set_a(2'b00, 32'h0, 32'h0, 3'd0, 3'd0, 2'b00, 2'd0, 1'b0, 1'b0);
`ifdef MURE_PRIV_SPLIT_EN
        chk_a("split0", 1'b1, 32'hA00, 32'd2, 1'b1, 3'd0, 2'd3);
        a_ordy = 1'b1;
        tick();
        chk_a("split1", 1'b1, 32'hA04, 32'd2, 1'b1, 3'd0, 2'd0);
        tick();
`else
        chk_a("privhold", 1'b1, 32'hA00, 32'd4, 1'b1, 3'd0, 2'd3);
        a_ordy = 1'b1;
        tick();
`endif
        a_ordy = 1'b0;
        chk("priv.drained", 64'(a_ov), 64'(1'b0));

        // backpressure: one closing lane per cycle, consumer stalled
        for (int k = 1; k <= NFILL; k++) begin
            set_a(2'b01, 32'h1000 + 32'(4*(k-1)), 32'h0, 3'd1, 3'd0, 2'b00, 2'd1, 1'b0, 1'b0);
            tick();
            chk($sformatf("bp.ready%0d", k), 64'(a_ird), 64'((DEPTH - k) >= NEED));
            chk($sformatf("bp.head%0d", k), 64'(a_iaddr), 64'(32'h1000));
        end
        set_a(2'b01, 32'h1000 + 32'(4*NFILL), 32'h0, 3'd1, 3'd0, 2'b00, 2'd1, 1'b0, 1'b0);
        for (int k = 0; k < 2; k++) begin
            tick();
            chk($sformatf("bp.hold%0d", k), 64'(a_ird), 64'(1'b0));
        end
        a_ordy = 1'b1;
        tick();
        a_ordy = 1'b0;
        chk("bp.reopen", 64'(a_ird), 64'(1'b1));
        chk("bp.afterpop", 64'(a_iaddr), 64'(32'h1004));
        tick();
        a_valid = 2'b00;
        chk("bp.refull", 64'(a_ird), 64'(1'b0));
        for (int j = 0; j < NFILL; j++) begin
            chk($sformatf("bp.drain%0d", j), 64'(a_iaddr), 64'(32'h1004 + 32'(4*j)));
            chk($sformatf("bp.drainv%0d", j), 64'(a_ov), 64'(1'b1));
            a_ordy = 1'b1;
            tick();
        end
        a_ordy = 1'b0;
        chk("bp.empty", 64'(a_ov), 64'(1'b0));

        // counter saturation on the 4-bit instance
        for (int k = 0; k < 7; k++) begin
            b_valid = 2'b01;
            b_pc    = {32'h0, 32'h400 + 32'(4*k)};
            b_itype = 6'h0;
            tick();
            if (k < 6) chk($sformatf("sat.open%0d", k), 64'(b_ov), 64'(1'b0));
        end
        chk("sat.valid", 64'(b_ov), 64'(1'b1));
        chk("sat.iaddr", 64'(b_iaddr), 64'(32'h400));
        chk("sat.iretire", 64'(b_iret), 64'(4'd14));
        chk("sat.lastsize", 64'(b_last), 64'(1'b1));
        chk("sat.itype", 64'(b_it), 64'(3'd0));
        b_pc    = {32'h0, 32'h41C};
        b_itype = {3'd0, 3'd1};
        b_ordy  = 1'b1;
        tick();
        chk("sat.next.iaddr", 64'(b_iaddr), 64'(32'h41C));
        chk("sat.next.iretire", 64'(b_iret), 64'(4'd2));
        chk("sat.next.itype", 64'(b_it), 64'(3'd1));
        b_valid = 2'b00;
        tick();
        b_ordy = 1'b0;
        chk("sat.empty", 64'(b_ov), 64'(1'b0));

        // reset mid-stream with three entries queued
        set_a(2'b11, 32'h900, 32'h904, 3'd1, 3'd2, 2'b00, 2'd1, 1'b0, 1'b0);
        tick();
        set_a(2'b01, 32'h908, 32'h0, 3'd3, 3'd0, 2'b00, 2'd1, 1'b0, 1'b0);
        tick();
        a_valid = 2'b00;
        chk("mid.queued", 64'(a_iaddr), 64'(32'h900));
        #2;
        rst = 1'b1;
        #1;
        chk_a("mid.reset", 1'b0, 32'h0, 32'd0, 1'b0, 3'd0, 2'd0);
        chk("mid.reset.in_ready", 64'(a_ird), 64'(1'b1));
        @(negedge clk);
        rst = 1'b0;
        set_a(2'b01, 32'h800, 32'h0, 3'd1, 3'd0, 2'b01, 2'd1, 1'b0, 1'b0);
        tick();
        chk_a("mid.fresh", 1'b1, 32'h800, 32'd1, 1'b0, 3'd1, 2'd1);
        set_a(2'b00, 32'h0, 32'h0, 3'd0, 3'd0, 2'b00, 2'd0, 1'b0, 1'b1);
        tick();
        chk("mid.empty", 64'(a_ov), 64'(1'b0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
